// File: rtl/counter_general_core.sv
// Prescaled up/down counter with one-shot/auto-reload modes, driven by the counter_general register slave.
// Optional capture input enabled by defining COUNTER_GENERAL_CAPTURE_EN.
module counter_general_core #(
    parameter int C_DATA_WIDTH  = 32,
    parameter int C_PRESC_WIDTH = 8
) (
    input  logic                     ACLK,
    input  logic                     ARESETN,
    input  logic                     cmd_start,
    input  logic                     cmd_stop,
    input  logic                     cmd_clear,
    input  logic                     cfg_reload,
    input  logic                     cfg_down,
    input  logic [C_PRESC_WIDTH-1:0] cfg_presc,
    input  logic [C_DATA_WIDTH-1:0]  cfg_load,
    input  logic [C_DATA_WIDTH-1:0]  cfg_period,
`ifdef COUNTER_GENERAL_CAPTURE_EN
    input  logic                     cap_in,
    output logic [C_DATA_WIDTH-1:0]  cap_value,
    output logic                     cap_valid,
`endif
    output logic [C_DATA_WIDTH-1:0]  cnt_value,
    output logic                     cnt_busy,
    output logic                     cnt_paused,
    output logic                     cnt_done,
    output logic                     cnt_tick
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RUN    = 2'd1,
        PAUSED = 2'd2,
        DONE   = 2'd3
    } state_t;

    localparam logic [C_DATA_WIDTH-1:0]  CNT_ONE   = C_DATA_WIDTH'(1);
    localparam logic [C_PRESC_WIDTH-1:0] PRESC_ONE = C_PRESC_WIDTH'(1);

    state_t                   state_q, state_d;
    logic [C_DATA_WIDTH-1:0]  cnt_q, cnt_d;
    logic [C_PRESC_WIDTH-1:0] presc_q, presc_d;
    logic                     done_q, done_d;
    logic                     tick_q, tick_d;
    logic                     busy_q, busy_d;
    logic                     paused_q, paused_d;
    logic                     terminal;

    // Command priority is clear > stop > start; a stop pulse swallows a start even when it has no effect itself.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        presc_d  = presc_q;
        done_d   = done_q;
        tick_d   = 1'b0;
        terminal = cfg_down ? (cnt_q == '0) : (cnt_q == cfg_period);

        if (cmd_clear) begin
            state_d = IDLE;
            cnt_d   = '0;
            presc_d = '0;
            done_d  = 1'b0;
        end else if (cmd_stop) begin
            if (state_q == RUN) begin
                state_d = PAUSED;
            end
        end else if (cmd_start && (state_q == IDLE || state_q == DONE)) begin
            state_d = RUN;
            cnt_d   = cfg_load;
            presc_d = '0;
            done_d  = 1'b0;
        end else if (cmd_start && state_q == PAUSED) begin
            state_d = RUN;
        end else if (state_q == RUN) begin
            if (presc_q == cfg_presc) begin
                presc_d = '0;
                if (terminal) begin
                    tick_d = 1'b1;
                    if (cfg_reload) begin
                        cnt_d = cfg_load;
                    end else begin
                        state_d = DONE;
                        done_d  = 1'b1;
                    end
                end else if (cfg_down) begin
                    cnt_d = cnt_q - CNT_ONE;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end else begin
                presc_d = presc_q + PRESC_ONE;
            end
        end

        busy_d   = (state_d == RUN);
        paused_d = (state_d == PAUSED);
    end

    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            presc_q  <= '0;
            done_q   <= 1'b0;
            tick_q   <= 1'b0;
            busy_q   <= 1'b0;
            paused_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            presc_q  <= presc_d;
            done_q   <= done_d;
            tick_q   <= tick_d;
            busy_q   <= busy_d;
            paused_q <= paused_d;
        end
    end

    assign cnt_value  = cnt_q;
    assign cnt_busy   = busy_q;
    assign cnt_paused = paused_q;
    assign cnt_done   = done_q;
    assign cnt_tick   = tick_q;

`ifdef COUNTER_GENERAL_CAPTURE_EN
    logic [2:0]              cap_sync_q, cap_sync_d;
    logic [C_DATA_WIDTH-1:0] cap_value_q, cap_value_d;
    logic                    cap_valid_q, cap_valid_d;
    logic                    cap_edge;

    // Two synchronizer stages plus one history stage; sampling cnt_q keeps the pre-step value on a terminal step.
    always_comb begin
        cap_sync_d  = {cap_sync_q[1:0], cap_in};
        cap_edge    = cap_sync_q[1] & ~cap_sync_q[2];
        cap_value_d = cap_value_q;
        cap_valid_d = cap_valid_q;
        if (cmd_clear) begin
            cap_value_d = '0;
            cap_valid_d = 1'b0;
        end else if (cap_edge && (state_q == RUN || state_q == PAUSED)) begin
            cap_value_d = cnt_q;
            cap_valid_d = 1'b1;
        end
    end

    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            cap_sync_q  <= '0;
            cap_value_q <= '0;
            cap_valid_q <= 1'b0;
        end else begin
            cap_sync_q  <= cap_sync_d;
            cap_value_q <= cap_value_d;
            cap_valid_q <= cap_valid_d;
        end
    end

    assign cap_value = cap_value_q;
    assign cap_valid = cap_valid_q;
`endif

endmodule

// File: tb/tb_counter_general_core.sv
// Directed bench for counter_general_core built with an 8-bit counter so wrap-around is quick to reach.
// Capture checks are compiled in when COUNTER_GENERAL_CAPTURE_EN is defined.
module tb_counter_general_core;

    localparam int DW = 8;
    localparam int PW = 8;

    logic          ACLK = 1'b0;
    logic          ARESETN;
    logic          cmd_start, cmd_stop, cmd_clear;
    logic          cfg_reload, cfg_down;
    logic [PW-1:0] cfg_presc;
    logic [DW-1:0] cfg_load, cfg_period;
    logic [DW-1:0] cnt_value;
    logic          cnt_busy, cnt_paused, cnt_done, cnt_tick;
`ifdef COUNTER_GENERAL_CAPTURE_EN
    logic          cap_in;
    logic [DW-1:0] cap_value;
    logic          cap_valid;
`endif

    int checks = 0;
    int errors = 0;

    counter_general_core #(
        .C_DATA_WIDTH  (DW),
        .C_PRESC_WIDTH (PW)
    ) dut (
        .ACLK       (ACLK),
        .ARESETN    (ARESETN),
        .cmd_start  (cmd_start),
        .cmd_stop   (cmd_stop),
        .cmd_clear  (cmd_clear),
        .cfg_reload (cfg_reload),
        .cfg_down   (cfg_down),
        .cfg_presc  (cfg_presc),
        .cfg_load   (cfg_load),
        .cfg_period (cfg_period),
`ifdef COUNTER_GENERAL_CAPTURE_EN
        .cap_in     (cap_in),
        .cap_value  (cap_value),
        .cap_valid  (cap_valid),
`endif
        .cnt_value  (cnt_value),
        .cnt_busy   (cnt_busy),
        .cnt_paused (cnt_paused),
        .cnt_done   (cnt_done),
        .cnt_tick   (cnt_tick)
    );

    always #5 ACLK = ~ACLK;

    // Advance one clock and settle just after the edge so registered outputs are stable.
    task automatic cyc();
        @(posedge ACLK);
        #1;
    endtask

    task automatic pulse_start();
        cmd_start = 1'b1;
        cyc();
        cmd_start = 1'b0;
    endtask

    task automatic pulse_clear();
        cmd_clear = 1'b1;
        cyc();
        cmd_clear = 1'b0;
    endtask

    // Flags below are always compared as {busy, paused, done, tick}.
    task automatic test_reset();
        ARESETN    = 1'b0;
        cfg_load   = DW'($urandom);
        cfg_period = DW'($urandom);
        cfg_presc  = PW'($urandom);
        cfg_down   = 1'($urandom);
        cfg_reload = 1'($urandom);
        #200;
        checks++;
        if ({cnt_busy, cnt_paused, cnt_done, cnt_tick} !== 4'b0000 || cnt_value !== 8'h00) begin
            errors++;
            $display("[TB] FAIL reset_hold: flags %b value %h, expected 0000 / 00",
                     {cnt_busy, cnt_paused, cnt_done, cnt_tick}, cnt_value);
        end
        @(posedge ACLK);
        #1;
        ARESETN = 1'b1;
        for (int i = 0; i < 4; i++) begin
            cyc();
            checks++;
            if ({cnt_busy, cnt_paused, cnt_done, cnt_tick} !== 4'b0000 || cnt_value !== 8'h00) begin
                errors++;
                $display("[TB] FAIL reset_idle[%0d]: flags %b value %h, expected 0000 / 00",
                         i, {cnt_busy, cnt_paused, cnt_done, cnt_tick}, cnt_value);
            end
        end
    endtask

    task automatic test_oneshot_up();
        int ticks;
        ticks      = 0;
        cfg_load   = 8'd1;
        cfg_period = 8'd4;
        cfg_presc  = '0;
        cfg_down   = 1'b0;
        cfg_reload = 1'b0;
        pulse_start();
        for (int i = 1; i <= 4; i++) begin
            checks++;
            if (cnt_value !== 8'(i) || cnt_busy !== 1'b1 || cnt_done !== 1'b0) begin
                errors++;
                $display("[TB] FAIL oneshot_count[%0d]: value %h busy %b done %b, expected %h / 1 / 0",
                         i, cnt_value, cnt_busy, cnt_done, 8'(i));
            end
            if (cnt_tick) ticks++;
            cyc();
        end
        if (cnt_tick) ticks++;
        checks++;
        if ({cnt_busy, cnt_paused, cnt_done, cnt_tick} !== 4'b0011 || cnt_value !== 8'd4) begin
            errors++;
            $display("[TB] FAIL oneshot_terminal: flags %b value %h, expected 0011 / 04",
                     {cnt_busy, cnt_paused, cnt_done, cnt_tick}, cnt_value);
        end
        cyc();
        if (cnt_tick) ticks++;
        checks++;
        if ({cnt_busy, cnt_paused, cnt_done, cnt_tick} !== 4'b0010 || cnt_value !== 8'd4) begin
            errors++;
            $display("[TB] FAIL oneshot_hold: flags %b value %h, expected 0010 / 04",
                     {cnt_busy, cnt_paused, cnt_done, cnt_tick}, cnt_value);
        end
        checks++;
        if (ticks !== 1) begin
            errors++;
            $display("[TB] FAIL oneshot_tick_count: got %0d, expected 1", ticks);
        end
    endtask

    task automatic test_reload_down();
        logic [DW-1:0] exp_v;
        logic          exp_t;
        cfg_load   = 8'd3;
        cfg_period = 8'd0;
        cfg_presc  = 8'd1;
        cfg_down   = 1'b1;
        cfg_reload = 1'b1;
        pulse_start();
        for (int k = 0; k <= 40; k++) begin
            exp_v = 8'(3 - ((k >> 1) & 3));
            exp_t = (k > 0) && (k % 8 == 0);
            checks++;
            if (cnt_value !== exp_v || cnt_tick !== exp_t || cnt_done !== 1'b0 || cnt_busy !== 1'b1) begin
                errors++;
                $display("[TB] FAIL reload_down[%0d]: value %h tick %b done %b busy %b, expected %h / %b / 0 / 1",
                         k, cnt_value, cnt_tick, cnt_done, cnt_busy, exp_v, exp_t);
            end
            cyc();
        end
        pulse_clear();
        checks++;
        if ({cnt_busy, cnt_paused, cnt_done, cnt_tick} !== 4'b0000 || cnt_value !== 8'h00) begin
            errors++;
            $display("[TB] FAIL clear_after_reload: flags %b value %h, expected 0000 / 00",
                     {cnt_busy, cnt_paused, cnt_done, cnt_tick}, cnt_value);
        end
    endtask

    task automatic test_pause_resume();
        cfg_load   = 8'd2;
        cfg_period = 8'd50;
        cfg_presc  = 8'd3;
        cfg_down   = 1'b0;
        cfg_reload = 1'b1;
        pulse_start();
        repeat (14) cyc();
        checks++;
        if (cnt_value !== 8'd5 || cnt_busy !== 1'b1) begin
            errors++;
            $display("[TB] FAIL pause_prerun: value %h busy %b, expected 05 / 1", cnt_value, cnt_busy);
        end
        cmd_stop = 1'b1;
        cyc();
        cmd_stop = 1'b0;
        checks++;
        if ({cnt_busy, cnt_paused} !== 2'b01 || cnt_value !== 8'd5) begin
            errors++;
            $display("[TB] FAIL pause_enter: busy/paused %b value %h, expected 01 / 05",
                     {cnt_busy, cnt_paused}, cnt_value);
        end
        repeat (20) cyc();
        checks++;
        if ({cnt_busy, cnt_paused} !== 2'b01 || cnt_value !== 8'd5) begin
            errors++;
            $display("[TB] FAIL pause_hold: busy/paused %b value %h, expected 01 / 05",
                     {cnt_busy, cnt_paused}, cnt_value);
        end
        pulse_start();
        checks++;
        if ({cnt_busy, cnt_paused} !== 2'b10 || cnt_value !== 8'd5) begin
            errors++;
            $display("[TB] FAIL resume_enter: busy/paused %b value %h, expected 10 / 05",
                     {cnt_busy, cnt_paused}, cnt_value);
        end
        cyc();
        checks++;
        if (cnt_value !== 8'd5) begin
            errors++;
            $display("[TB] FAIL resume_wait: value %h, expected 05", cnt_value);
        end
        cyc();
        checks++;
        if (cnt_value !== 8'd6) begin
            errors++;
            $display("[TB] FAIL resume_step: value %h, expected 06", cnt_value);
        end
    endtask

    task automatic test_simultaneous();
        cfg_load   = 8'd10;
        cfg_period = 8'd200;
        cfg_presc  = '0;
        cfg_down   = 1'b0;
        cfg_reload = 1'b1;
        pulse_clear();
        pulse_start();
        cyc();
        cmd_start = 1'b1;
        cyc();
        cmd_start = 1'b0;
        checks++;
        if (cnt_value !== 8'd12 || cnt_busy !== 1'b1) begin
            errors++;
            $display("[TB] FAIL start_in_run: value %h busy %b, expected 0c / 1", cnt_value, cnt_busy);
        end
        cmd_stop  = 1'b1;
        cmd_start = 1'b1;
        cyc();
        cmd_stop  = 1'b0;
        cmd_start = 1'b0;
        checks++;
        if ({cnt_busy, cnt_paused} !== 2'b01 || cnt_value !== 8'd12) begin
            errors++;
            $display("[TB] FAIL stop_start_run: busy/paused %b value %h, expected 01 / 0c",
                     {cnt_busy, cnt_paused}, cnt_value);
        end
        cmd_stop  = 1'b1;
        cmd_start = 1'b1;
        cyc();
        cmd_stop  = 1'b0;
        cmd_start = 1'b0;
        checks++;
        if ({cnt_busy, cnt_paused} !== 2'b01 || cnt_value !== 8'd12) begin
            errors++;
            $display("[TB] FAIL stop_start_paused: busy/paused %b value %h, expected 01 / 0c",
                     {cnt_busy, cnt_paused}, cnt_value);
        end
        pulse_start();
        cyc();
        checks++;
        if (cnt_busy !== 1'b1 || cnt_value !== 8'd13) begin
            errors++;
            $display("[TB] FAIL resume_after_drop: busy %b value %h, expected 1 / 0d", cnt_busy, cnt_value);
        end
        cmd_clear = 1'b1;
        cmd_stop  = 1'b1;
        cmd_start = 1'b1;
        cyc();
        cmd_clear = 1'b0;
        cmd_stop  = 1'b0;
        cmd_start = 1'b0;
        checks++;
        if ({cnt_busy, cnt_paused, cnt_done, cnt_tick} !== 4'b0000 || cnt_value !== 8'h00) begin
            errors++;
            $display("[TB] FAIL clear_wins: flags %b value %h, expected 0000 / 00",
                     {cnt_busy, cnt_paused, cnt_done, cnt_tick}, cnt_value);
        end
    endtask

    task automatic test_degenerate();
        cfg_load   = 8'd0;
        cfg_period = 8'd99;
        cfg_presc  = '0;
        cfg_down   = 1'b1;
        cfg_reload = 1'b0;
        pulse_start();
        checks++;
        if ({cnt_busy, cnt_done, cnt_tick} !== 3'b100 || cnt_value !== 8'd0) begin
            errors++;
            $display("[TB] FAIL down_zero_load: busy/done/tick %b value %h, expected 100 / 00",
                     {cnt_busy, cnt_done, cnt_tick}, cnt_value);
        end
        cyc();
        checks++;
        if ({cnt_busy, cnt_done, cnt_tick} !== 3'b011 || cnt_value !== 8'd0) begin
            errors++;
            $display("[TB] FAIL down_zero_terminal: busy/done/tick %b value %h, expected 011 / 00",
                     {cnt_busy, cnt_done, cnt_tick}, cnt_value);
        end
        cfg_load   = 8'd7;
        cfg_period = 8'd7;
        cfg_down   = 1'b0;
        pulse_start();
        checks++;
        if ({cnt_busy, cnt_done, cnt_tick} !== 3'b100 || cnt_value !== 8'd7) begin
            errors++;
            $display("[TB] FAIL up_equal_start: busy/done/tick %b value %h, expected 100 / 07",
                     {cnt_busy, cnt_done, cnt_tick}, cnt_value);
        end
        cyc();
        checks++;
        if ({cnt_busy, cnt_done, cnt_tick} !== 3'b011 || cnt_value !== 8'd7) begin
            errors++;
            $display("[TB] FAIL up_equal_terminal: busy/done/tick %b value %h, expected 011 / 07",
                     {cnt_busy, cnt_done, cnt_tick}, cnt_value);
        end
    endtask

    task automatic test_wrap();
        logic [DW-1:0] seq [4];
        seq[0] = 8'hFE;
        seq[1] = 8'hFF;
        seq[2] = 8'h00;
        seq[3] = 8'h01;
        pulse_clear();
        cfg_load   = 8'hFE;
        cfg_period = 8'h01;
        cfg_presc  = '0;
        cfg_down   = 1'b0;
        cfg_reload = 1'b0;
        cmd_start  = 1'b1;
`ifdef COUNTER_GENERAL_CAPTURE_EN
        cap_in     = 1'b1;
`endif
        cyc();
        cmd_start = 1'b0;
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (cnt_value !== seq[i] || cnt_busy !== 1'b1) begin
                errors++;
                $display("[TB] FAIL wrap_seq[%0d]: value %h busy %b, expected %h / 1",
                         i, cnt_value, cnt_busy, seq[i]);
            end
            cyc();
        end
        checks++;
        if ({cnt_busy, cnt_done, cnt_tick} !== 3'b011 || cnt_value !== 8'h01) begin
            errors++;
            $display("[TB] FAIL wrap_done: busy/done/tick %b value %h, expected 011 / 01",
                     {cnt_busy, cnt_done, cnt_tick}, cnt_value);
        end
`ifdef COUNTER_GENERAL_CAPTURE_EN
        checks++;
        if (cap_value !== 8'hFF || cap_valid !== 1'b1) begin
            errors++;
            $display("[TB] FAIL capture_value: value %h valid %b, expected ff / 1", cap_value, cap_valid);
        end
        pulse_clear();
        cap_in = 1'b0;
        checks++;
        if (cap_value !== 8'h00 || cap_valid !== 1'b0) begin
            errors++;
            $display("[TB] FAIL capture_clear: value %h valid %b, expected 00 / 0", cap_value, cap_valid);
        end
`endif
    endtask

    task automatic test_reset_mid_run();
        cfg_load   = 8'h20;
        cfg_period = 8'h80;
        cfg_presc  = '0;
        cfg_down   = 1'b0;
        cfg_reload = 1'b1;
        pulse_start();
        repeat (3) cyc();
        checks++;
        if (cnt_value !== 8'h23 || cnt_busy !== 1'b1) begin
            errors++;
            $display("[TB] FAIL midrun_prerun: value %h busy %b, expected 23 / 1", cnt_value, cnt_busy);
        end
        #2;
        ARESETN = 1'b0;
        #1;
        checks++;
        if ({cnt_busy, cnt_paused, cnt_done, cnt_tick} !== 4'b0000 || cnt_value !== 8'h00) begin
            errors++;
            $display("[TB] FAIL midrun_async: flags %b value %h, expected 0000 / 00",
                     {cnt_busy, cnt_paused, cnt_done, cnt_tick}, cnt_value);
        end
        repeat (2) cyc();
        ARESETN = 1'b1;
        cyc();
        checks++;
        if ({cnt_busy, cnt_paused, cnt_done, cnt_tick} !== 4'b0000 || cnt_value !== 8'h00) begin
            errors++;
            $display("[TB] FAIL midrun_release: flags %b value %h, expected 0000 / 00",
                     {cnt_busy, cnt_paused, cnt_done, cnt_tick}, cnt_value);
        end
    endtask

    initial begin
        ARESETN    = 1'b0;
        cmd_start  = 1'b0;
        cmd_stop   = 1'b0;
        cmd_clear  = 1'b0;
        cfg_reload = 1'b0;
        cfg_down   = 1'b0;
        cfg_presc  = '0;
        cfg_load   = '0;
        cfg_period = '0;
`ifdef COUNTER_GENERAL_CAPTURE_EN
        cap_in     = 1'b0;
`endif
        test_reset();
        test_oneshot_up();
        test_reload_down();
        test_pause_resume();
        test_simultaneous();
        test_degenerate();
        test_wrap();
        test_reset_mid_run();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
